// File: rtl/mem_scan_reader.sv
// mem_scan_reader: steps through a small memory, showing each entry on a 7-segment display for DWELL cycles.
module mem_scan_reader #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4,
  parameter int DWELL = 4
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cont,
  input  logic                  hold,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [7:0]            SEG,
  output logic [7:0]            LED,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, SHOW} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  localparam logic [7:0] CNT_INIT = 8'(DWELL - 1);
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] cur_addr, addr_nx;
  logic [7:0] cnt, cnt_nx, seg_raw;
  logic [DATA_WIDTH-1:0] shown, shown_nx;
  logic valid, valid_nx, done_nx;
  logic [3:0] digit;
  logic [1:0] addr_lo;
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state <= IDLE;
      cur_addr <= '0;
      cnt <= '0;
      shown <= '0;
      valid <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      cur_addr <= addr_nx;
      cnt <= cnt_nx;
      shown <= shown_nx;
      valid <= valid_nx;
      done <= done_nx;
    end
  end
  always_comb begin
    state_nx = state;
    addr_nx = cur_addr;
    cnt_nx = cnt;
    shown_nx = shown;
    valid_nx = valid;
    done_nx = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nx = REQ;
        addr_nx = '0;
      end
      REQ: state_nx = WAIT;
      WAIT: begin
        shown_nx = rd_data;
        valid_nx = 1'b1;
        cnt_nx = CNT_INIT;
        state_nx = SHOW;
      end
      SHOW: if (!hold) begin
        if (cnt != '0) cnt_nx = cnt - 8'd1;
        // wrap to entry 0 falls out of the address overflow
        else if (cur_addr != LAST || cont) begin
          addr_nx = cur_addr + 1'b1;
          state_nx = REQ;
        end else begin
          state_nx = IDLE;
          done_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  assign digit = 4'(shown);
  assign addr_lo = 2'(cur_addr);
  always_comb begin
    seg_raw = 8'h00;
    case (digit)
      4'h0: seg_raw = 8'h3F;
      4'h1: seg_raw = 8'h06;
      4'h2: seg_raw = 8'h5B;
      4'h3: seg_raw = 8'h4F;
      4'h4: seg_raw = 8'h66;
      4'h5: seg_raw = 8'h6D;
      4'h6: seg_raw = 8'h7D;
      4'h7: seg_raw = 8'h07;
      4'h8: seg_raw = 8'h7F;
      4'h9: seg_raw = 8'h6F;
      4'hA: seg_raw = 8'h77;
      4'hB: seg_raw = 8'h7C;
      4'hC: seg_raw = 8'h39;
      4'hD: seg_raw = 8'h5E;
      4'hE: seg_raw = 8'h79;
      default: seg_raw = 8'h71;
    endcase
  end
  assign rd_en = state == REQ;
  assign rd_addr = cur_addr;
  assign SEG = valid ? seg_raw : 8'h00;
  assign LED = {digit, addr_lo, state != IDLE, valid};
endmodule

// File: tb/tb_mem_scan_reader.sv
// tb_mem_scan_reader: randomized scans checked against an arithmetic schedule of reads, display and done pulses.
module tb_mem_scan_reader;
  logic clk_2 = 1'b0, reset, start, start_b, cont, hold;
  logic [3:0] rd_data, rd_data_b;
  logic rd_en, rd_en_b, done, done_b;
  logic [1:0] rd_addr, rd_addr_b;
  logic [7:0] SEG, LED, SEG_b, LED_b;
  logic [3:0] mem [4];
  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  int cyc = 0, n_tests = 0, n_fail = 0;
  int req_t[$], done_t[$], req_tb[$], done_tb[$];
  logic [1:0] req_a[$], req_ab[$];
  logic [7:0] seg_log [int], led_log [int], seg_log_b [int];

  mem_scan_reader dut (.clk_2(clk_2), .reset(reset), .start(start), .cont(cont), .hold(hold),
    .rd_data(rd_data), .rd_en(rd_en), .rd_addr(rd_addr), .SEG(SEG), .LED(LED), .done(done));
  mem_scan_reader #(.DWELL(1)) dut_b (.clk_2(clk_2), .reset(reset), .start(start_b), .cont(cont),
    .hold(hold), .rd_data(rd_data_b), .rd_en(rd_en_b), .rd_addr(rd_addr_b), .SEG(SEG_b),
    .LED(LED_b), .done(done_b));

  always #5 clk_2 = ~clk_2;
  always @(posedge clk_2) cyc <= cyc + 1;
  // memory answers one cycle after the strobe; noise otherwise exposes mistimed sampling
  always @(posedge clk_2) begin
    rd_data <= rd_en ? mem[rd_addr] : 4'($urandom);
    rd_data_b <= rd_en_b ? mem[rd_addr_b] : 4'($urandom);
  end
  always @(negedge clk_2) begin
    seg_log[cyc] = SEG;
    led_log[cyc] = LED;
    seg_log_b[cyc] = SEG_b;
    if (rd_en) begin req_t.push_back(cyc); req_a.push_back(rd_addr); end
    if (done) done_t.push_back(cyc);
    if (rd_en_b) begin req_tb.push_back(cyc); req_ab.push_back(rd_addr_b); end
    if (done_b) done_tb.push_back(cyc);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_2); #1; end
  endtask

  task automatic clear_logs();
    req_t.delete(); req_a.delete(); done_t.delete();
    req_tb.delete(); req_ab.delete(); done_tb.delete();
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 4; i++) mem[i] = 4'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    n_tests++; if (SEG !== 8'h00) begin n_fail++; $display("FAIL reset_seg got %h want 00", SEG); end
    n_tests++; if (LED !== 8'h00) begin n_fail++; $display("FAIL reset_led got %h want 00", LED); end
    n_tests++; if ({rd_en, done, rd_addr} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl got %b want 0000", {rd_en, done, rd_addr}); end
    n_tests++; if (SEG_b !== 8'h00 || LED_b !== 8'h00) begin n_fail++; $display("FAIL reset_b got %h/%h want 00/00", SEG_b, LED_b); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_single_scan(input bit fixed);
    int t0;
    if (fixed) mem = '{4'h3, 4'hA, 4'hF, 4'h0}; else randomize_mem();
    clear_logs();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    t0 = cyc;
    tick(30);
    n_tests++; if (req_t.size() != 4) begin n_fail++; $display("FAIL scan_req_count got %0d want 4", req_t.size()); end
    for (int k = 0; k < 4 && k < req_t.size(); k++) begin
      n_tests++; if (req_t[k] != t0 + 6 * k || req_a[k] !== 2'(k)) begin n_fail++; $display("FAIL scan_req%0d got t=%0d a=%0d want t=%0d a=%0d", k, req_t[k], req_a[k], t0 + 6 * k, k); end
      n_tests++; if (seg_log[t0 + 6 * k + 2] !== seg_tab[mem[k]]) begin n_fail++; $display("FAIL scan_seg%0d got %h want %h", k, seg_log[t0 + 6 * k + 2], seg_tab[mem[k]]); end
      n_tests++; if (led_log[t0 + 6 * k + 2] !== {mem[k], 2'(k), 2'b11}) begin n_fail++; $display("FAIL scan_led%0d got %h want %h", k, led_log[t0 + 6 * k + 2], {mem[k], 2'(k), 2'b11}); end
    end
    n_tests++; if (done_t.size() != 1 || done_t[0] != t0 + 24) begin n_fail++; $display("FAIL scan_done got n=%0d t=%0d want n=1 t=%0d", done_t.size(), done_t.size() ? done_t[0] : -1, t0 + 24); end
    n_tests++; if (led_log[t0 + 24] !== {mem[3], 2'b11, 2'b01} || seg_log[t0 + 28] !== seg_tab[mem[3]]) begin n_fail++; $display("FAIL scan_retain got %h/%h want %h/%h", led_log[t0 + 24], seg_log[t0 + 28], {mem[3], 2'b11, 2'b01}, seg_tab[mem[3]]); end
  endtask

  task automatic test_cont();
    int t0;
    randomize_mem();
    clear_logs();
    cont = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    t0 = cyc;
    tick(50);
    n_tests++; if (done_t.size() != 0) begin n_fail++; $display("FAIL cont_nodone got %0d pulses want 0", done_t.size()); end
    cont = 1'b0;
    tick(30);
    n_tests++; if (req_t.size() != 12) begin n_fail++; $display("FAIL cont_req_count got %0d want 12", req_t.size()); end
    for (int k = 0; k < 12 && k < req_t.size(); k++) begin
      n_tests++; if (req_t[k] != t0 + 6 * k || req_a[k] !== 2'(k % 4)) begin n_fail++; $display("FAIL cont_req%0d got t=%0d a=%0d want t=%0d a=%0d", k, req_t[k], req_a[k], t0 + 6 * k, k % 4); end
    end
    n_tests++; if (done_t.size() != 1 || done_t[0] != t0 + 72) begin n_fail++; $display("FAIL cont_done got n=%0d t=%0d want n=1 t=%0d", done_t.size(), done_t.size() ? done_t[0] : -1, t0 + 72); end
  endtask

  task automatic test_hold();
    int t0;
    int exp_req [4];
    randomize_mem();
    clear_logs();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    t0 = cyc;
    tick(8);
    hold = 1'b1;
    tick(10);
    hold = 1'b0;
    tick(25);
    exp_req = '{t0, t0 + 6, t0 + 22, t0 + 28};
    n_tests++; if (req_t.size() != 4) begin n_fail++; $display("FAIL hold_req_count got %0d want 4", req_t.size()); end
    for (int k = 0; k < 4 && k < req_t.size(); k++) begin
      n_tests++; if (req_t[k] != exp_req[k]) begin n_fail++; $display("FAIL hold_req%0d got t=%0d want t=%0d", k, req_t[k], exp_req[k]); end
    end
    for (int t = t0 + 8; t < t0 + 22; t++) begin
      n_tests++; if (seg_log[t] !== seg_tab[mem[1]]) begin n_fail++; $display("FAIL hold_seg@%0d got %h want %h", t - t0, seg_log[t], seg_tab[mem[1]]); end
    end
    n_tests++; if (done_t.size() != 1 || done_t[0] != t0 + 34) begin n_fail++; $display("FAIL hold_done got n=%0d t=%0d want n=1 t=%0d", done_t.size(), done_t.size() ? done_t[0] : -1, t0 + 34); end
  endtask

  task automatic test_reset_mid();
    int t0;
    randomize_mem();
    clear_logs();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    t0 = cyc;
    tick(13);
    n_tests++; if (req_t.size() != 3 || req_a[req_a.size() - 1] !== 2'd2) begin n_fail++; $display("FAIL midrst_pre got n=%0d want 3 reads ending at addr 2", req_t.size()); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    n_tests++; if (SEG !== 8'h00 || LED !== 8'h00) begin n_fail++; $display("FAIL midrst_disp got %h/%h want 00/00", SEG, LED); end
    n_tests++; if (rd_en !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl got rd_en=%b done=%b want 0/0", rd_en, done); end
    tick(30);
    n_tests++; if (req_t.size() != 3 || done_t.size() != 0) begin n_fail++; $display("FAIL midrst_quiet got reads=%0d dones=%0d want 3/0", req_t.size(), done_t.size()); end
  endtask

  task automatic test_back_to_back();
    int t0;
    randomize_mem();
    clear_logs();
    start = 1'b1;
    tick(1);
    t0 = cyc;
    tick(55);
    start = 1'b0;
    tick(30);
    n_tests++; if (done_t.size() != 3) begin n_fail++; $display("FAIL b2b_done_count got %0d want 3", done_t.size()); end
    for (int j = 0; j < 3 && j < done_t.size(); j++) begin
      n_tests++; if (done_t[j] != t0 + 24 + 25 * j) begin n_fail++; $display("FAIL b2b_done%0d got t=%0d want t=%0d", j, done_t[j], t0 + 24 + 25 * j); end
    end
    n_tests++; if (req_t.size() != 12) begin n_fail++; $display("FAIL b2b_req_count got %0d want 12", req_t.size()); end
    for (int k = 0; k < 12 && k < req_t.size(); k++) begin
      n_tests++; if (req_t[k] != t0 + 25 * (k / 4) + 6 * (k % 4) || req_a[k] !== 2'(k % 4)) begin n_fail++; $display("FAIL b2b_req%0d got t=%0d a=%0d want t=%0d a=%0d", k, req_t[k], req_a[k], t0 + 25 * (k / 4) + 6 * (k % 4), k % 4); end
    end
  endtask

  task automatic test_dwell1();
    int t0;
    randomize_mem();
    clear_logs();
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    t0 = cyc;
    tick(20);
    n_tests++; if (req_tb.size() != 4) begin n_fail++; $display("FAIL d1_req_count got %0d want 4", req_tb.size()); end
    for (int k = 0; k < 4 && k < req_tb.size(); k++) begin
      n_tests++; if (req_tb[k] != t0 + 3 * k || req_ab[k] !== 2'(k)) begin n_fail++; $display("FAIL d1_req%0d got t=%0d a=%0d want t=%0d a=%0d", k, req_tb[k], req_ab[k], t0 + 3 * k, k); end
      n_tests++; if (seg_log_b[t0 + 3 * k + 2] !== seg_tab[mem[k]]) begin n_fail++; $display("FAIL d1_seg%0d got %h want %h", k, seg_log_b[t0 + 3 * k + 2], seg_tab[mem[k]]); end
    end
    n_tests++; if (done_tb.size() != 1 || done_tb[0] != t0 + 12) begin n_fail++; $display("FAIL d1_done got n=%0d t=%0d want n=1 t=%0d", done_tb.size(), done_tb.size() ? done_tb[0] : -1, t0 + 12); end
  endtask

  initial begin
    {reset, start, start_b, cont, hold} = '0;
    mem = '{4'h0, 4'h0, 4'h0, 4'h0};
    test_reset();
    test_single_scan(1'b1);
    for (int i = 0; i < 3; i++) test_single_scan(1'b0);
    test_cont();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_dwell1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_scan_reader.md
MEM_SCAN_READER -- requirements
Module: mem_scan_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 2: read-address width; the memory holds 2**ADDR_WIDTH entries.
REQ-002 Parameter DATA_WIDTH, default 4: entry width; one hex digit.
REQ-003 Parameter DWELL, default 4, legal range 1..255: cycles each entry stays displayed.
REQ-004 clk_2  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 start  input  1: level; begins a scan when sampled high in IDLE.
REQ-007 cont  input  1: continuous mode; the scan wraps instead of stopping.
REQ-008 hold  input  1: freezes the dwell countdown while high.
REQ-009 rd_data  input  DATA_WIDTH: memory read data, valid the cycle after rd_en.
REQ-010 rd_en  output  1: read strobe to memory.
REQ-011 rd_addr  output  ADDR_WIDTH: read address.
REQ-012 SEG  output  8: 7-segment pattern of the displayed entry.
REQ-013 LED  output  8: status, {shown[3:0], cur_addr[1:0], busy, valid}.
REQ-014 done  output  1: one-cycle pulse when a non-continuous scan completes.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, SHOW, with all transitions on the clk_2 rising edge.
REQ-016 IDLE: rd_en=0; start=1 -> REQ with cur_addr=0; otherwise stay in IDLE.
REQ-017 REQ: rd_en=1 and rd_addr=cur_addr for exactly this one cycle; next state is always WAIT.
REQ-018 WAIT: rd_en=0; at the closing edge, shown<=rd_data, valid<=1, dwell counter<=DWELL-1, next state SHOW.
REQ-019 SHOW, counter>0: hold=0 decrements the counter; hold=1 keeps it unchanged; stay in SHOW.
REQ-020 SHOW, counter=0 and hold=0, cur_addr<max: cur_addr+1, next state REQ.
REQ-021 SHOW, counter=0 and hold=0, cur_addr=max, cont=1: cur_addr wraps to 0, next state REQ, no done pulse.
REQ-022 SHOW, counter=0 and hold=0, cur_addr=max, cont=0: next state IDLE, done=1 for one cycle; shown and valid are retained.
REQ-023 SHOW, counter=0 and hold=1: remain in SHOW until hold falls.
REQ-024 Per-entry time SHALL be 2+DWELL cycles; a full non-continuous scan SHALL take 2**ADDR_WIDTH*(2+DWELL) cycles from entry into REQ until IDLE.
REQ-025 start while not in IDLE is ignored; start held high in IDLE immediately re-triggers a scan, including the cycle after done.
REQ-026 cont is sampled only at the wrap decision; changing it mid-scan has no other effect.
REQ-027 busy=1 in REQ, WAIT and SHOW; busy=0 in IDLE.
REQ-028 SEG encoding: valid=0 -> 0x00; otherwise 0..F map to 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
REQ-029 rd_addr SHALL equal cur_addr at all times, and rd_en SHALL be asserted only in REQ.

Reset
REQ-030 reset=1 at an edge forces IDLE, cur_addr=0, counter=0, shown=0, valid=0, done=0 and rd_en=0, overriding all other inputs.
REQ-031 Reset in any state, mid-scan included, SHALL take effect at that edge, produce no done pulse, and leave no pending read.
REQ-032 After reset: SEG=0x00, LED=0x00.

Verification
REQ-033 Reset, then memory {0:3, 1:A, 2:F, 3:0}, DWELL=4, cont=0, start pulse -> rd_en pulses at addr 0,1,2,3 six cycles apart; SEG shows 4F, 77, 71, 3F in turn; done pulses once, 24 cycles after the first REQ.
REQ-034 cont=1, same memory -> after addr 3, rd_en fires at addr 0 six cycles later; no done pulse; runs for 3 full scans.
REQ-035 hold=1 for 10 cycles during SHOW of addr 1 -> SEG stays 77 for 14 cycles; the next rd_en is delayed by exactly 10 cycles.
REQ-036 reset asserted in the WAIT state for addr 2 -> next cycle IDLE, SEG=00, LED=00, rd_en=0; no done pulse.
REQ-037 start held high continuously, cont=0 -> back-to-back scans, with REQ at addr 0 entered the cycle after each done pulse.
REQ-038 DWELL=1 boundary -> one rd_en every 3 cycles; a full scan takes 12 cycles.
